div_unit: RTL

- Multi-cycle iterative 32-bit integer divider for the datapath; handles DIV/DIVU, the inverse of the combinational multiply in the execute stage.
- Operands are accepted through a start/busy/done handshake and shifted one quotient bit per cycle (radix-2 restoring).
- Quotient and remainder are held on the outputs for HI/LO write-back until the next completion.

---
 rtl/div_pkg.sv | 14 +
 rtl/div_step.sv | 21 ++
 rtl/div_unit.sv | 115 +++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider.
package div_pkg;

    localparam int DIV_WIDTH = 32;

    localparam logic [DIV_WIDTH-1:0] DBZ_QUOTIENT = '1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift in a dividend bit, trial-subtract.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             qbit_o
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;

    assign shifted = {rem_i, bit_i};
    // Extra top bit of diff is the borrow of the trial subtraction.
    assign diff    = {1'b0, shifted} - {2'b00, dvs_i};
    assign qbit_o  = ~diff[WIDTH+1];
    assign rem_o   = qbit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned 32-bit divider, one quotient bit per cycle.
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             dbz_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o
);

    div_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] dvd_q, dvs_q, rem_q;
    logic [WIDTH-1:0] quo_q, remo_q;
    logic             qneg_q, rneg_q;
    logic             busy_q, done_q, dbz_q;

    logic [WIDTH-1:0] rem_d, quo_d;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic             qbit;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i  (rem_q),
        .bit_i  (dvd_q[WIDTH-1]),
        .dvs_i  (dvs_q),
        .rem_o  (rem_d),
        .qbit_o (qbit)
    );

    // Dividend register doubles as the quotient shift register.
    assign quo_d = {dvd_q[WIDTH-2:0], qbit};

    always_comb begin
        dvd_mag = dividend_i;
        dvs_mag = divisor_i;
        if (signed_i && dividend_i[WIDTH-1]) dvd_mag = -dividend_i;
        if (signed_i && divisor_i[WIDTH-1])  dvs_mag = -divisor_i;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            remo_q  <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        busy_q <= 1'b1;
                        if (divisor_i == '0) begin
                            quo_q   <= DBZ_QUOTIENT[WIDTH-1:0];
                            remo_q  <= dividend_i;
                            dbz_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            dvd_q   <= dvd_mag;
                            dvs_q   <= dvs_mag;
                            rem_q   <= '0;
                            cnt_q   <= '0;
                            qneg_q  <= signed_i &
                                       (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
                            rneg_q  <= signed_i & dividend_i[WIDTH-1];
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    dvd_q <= quo_d;
                    rem_q <= rem_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        quo_q   <= qneg_q ? -quo_d : quo_d;
                        remo_q  <= rneg_q ? -rem_d : rem_d;
                        dbz_q   <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign dbz_o       = dbz_q;
    assign quotient_o  = quo_q;
    assign remainder_o = remo_q;

endmodule
